// File: rtl/mtr_pwm_decode.sv
// Motor PWM decoder: recovers an 11-bit signed speed from the duty cycle of a complementary
// PWM pair, flags a stuck line after TMO idle cycles and latches complementary violations.
module mtr_pwm_decode #(
    parameter int PERIOD = 2048,
    parameter int TMO    = 4096,
    parameter int MAXEQ  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PWM_sig,
    input  logic        PWM_sig_n,
    output logic [10:0] spd,
    output logic        vld,
    output logic        stuck,
    output logic        comp_err,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(((TMO > PERIOD) ? TMO : PERIOD) + 1);
    localparam int EW = (MAXEQ < 1) ? 1 : $clog2(MAXEQ + 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           sig_meta, sign_meta;
    logic           s, s_n, s_q;
    logic           rise;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [10:0]    high, high_nxt;
    logic [10:0]    spd_nxt;
    logic           vld_nxt;
    logic [EW-1:0]  eq_cnt;

    assign rise      = s & ~s_q;
    assign stuck     = (state == STUCK);
    assign dbg_state = state;

    // vld is a one-cycle strobe with no backpressure; spd is valid in the vld cycle and held after.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        high_nxt  = high;
        spd_nxt   = spd;
        vld_nxt   = 1'b0;
        unique case (state)
            SYNC, MEAS: begin
                if (rise) begin
                    if (state == MEAS && cnt == CW'(PERIOD)) begin
                        spd_nxt = high - 11'h400;
                        vld_nxt = 1'b1;
                    end
                    state_nxt = MEAS;
                    cnt_nxt   = CW'(1);
                    high_nxt  = 11'd1;
                end else if (cnt == CW'(TMO - 1)) begin
                    state_nxt = STUCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (s && high != 11'(PERIOD - 1)) begin
                        high_nxt = high + 11'd1;
                    end
                end
            end
            STUCK: begin
                if (rise) begin
                    state_nxt = MEAS;
                    cnt_nxt   = CW'(1);
                    high_nxt  = 11'd1;
                end else if (cnt == CW'(PERIOD - 1)) begin
                    // While stuck, report full-scale speed in the direction of the held level.
                    cnt_nxt = '0;
                    vld_nxt = 1'b1;
                    spd_nxt = s ? 11'h3FF : 11'h400;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = SYNC;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_meta  <= 1'b0;
            sign_meta <= 1'b0;
            s         <= 1'b0;
            s_n       <= 1'b0;
            s_q       <= 1'b0;
            state     <= SYNC;
            cnt       <= '0;
            high      <= '0;
            spd       <= '0;
            vld       <= 1'b0;
            eq_cnt    <= '0;
            comp_err  <= 1'b0;
        end else begin
            sig_meta  <= PWM_sig;
            sign_meta <= PWM_sig_n;
            s         <= sig_meta;
            s_n       <= sign_meta;
            s_q       <= s;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            high      <= high_nxt;
            spd       <= spd_nxt;
            vld       <= vld_nxt;
            // eq_cnt holds the run of equal cycles before this one, saturating at MAXEQ.
            if (s == s_n) begin
                if (eq_cnt == EW'(MAXEQ)) begin
                    comp_err <= 1'b1;
                end else begin
                    eq_cnt <= eq_cnt + EW'(1);
                end
            end else begin
                eq_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mtr_pwm_decode.sv
// Bench for mtr_pwm_decode: builds a pin-level stimulus script, derives expected outputs from
// edge timestamps and duty sums, then replays the script and compares every cycle.
module tb_mtr_pwm_decode;

    localparam int PERIOD = 2048;
    localparam int TMO    = 4096;
    localparam int MAXEQ  = 2;

    logic        clk;
    logic        rst;
    logic        pwm_sig;
    logic        pwm_sig_n;
    logic [10:0] spd;
    logic        vld;
    logic        stuck;
    logic        comp_err;
    logic [1:0]  dbg_state;

    mtr_pwm_decode #(.PERIOD(PERIOD), .TMO(TMO), .MAXEQ(MAXEQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .PWM_sig   (pwm_sig),
        .PWM_sig_n (pwm_sig_n),
        .spd       (spd),
        .vld       (vld),
        .stuck     (stuck),
        .comp_err  (comp_err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus script, one entry per cycle
    bit p_q[$];
    bit pn_q[$];
    bit r_q[$];

    // expected outputs per cycle and the ordered vld scoreboard
    bit          ss[];
    bit          ssn[];
    bit          e_vld[];
    bit          e_stuck[];
    bit          e_err[];
    logic [10:0] e_spd[];
    logic [10:0] exp_q[$];

    int n_chk;
    int n_err;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // driver tasks (script builders)
    task automatic put(input bit p, input bit pn, input bit r, input int n);
        for (int i = 0; i < n; i++) begin
            p_q.push_back(p);
            pn_q.push_back(pn);
            r_q.push_back(r);
        end
    endtask

    // One PWM period of length len, high for the first duty cycles; optionally both lines equal
    // for ov_n cycles starting at ov_at.
    task automatic pwm(input int duty, input int len, input int ov_at, input int ov_n);
        bit p;
        bit pn;
        for (int i = 0; i < len; i++) begin
            p  = (i < duty);
            pn = (ov_n > 0 && i >= ov_at && i < ov_at + ov_n) ? p : !p;
            put(p, pn, 1'b0, 1);
        end
    endtask

    // Reference: a pin value driven in cycle k is seen synchronized in cycle k+2 (zero while reset
    // clears the synchronizer); anything computed in cycle t is visible in cycle t+1.
    function automatic void build_model();
        int          n;
        int          last_edge;
        int          anchor;
        int          stuck_at;
        int          run;
        int          h;
        int          ref_t;
        bit          err;
        bit          v;
        bit          rise;
        logic [10:0] sv;
        n         = p_q.size();
        ss        = new[n];
        ssn       = new[n];
        e_vld     = new[n];
        e_stuck   = new[n];
        e_err     = new[n];
        e_spd     = new[n];
        last_edge = -1;
        anchor    = 0;
        stuck_at  = -1;
        run       = 0;
        err       = 1'b0;
        sv        = '0;
        for (int t = 0; t < n; t++) begin
            if (t < 2 || r_q[t-1] || r_q[t-2]) begin
                ss[t]  = 1'b0;
                ssn[t] = 1'b0;
            end else begin
                ss[t]  = p_q[t-2];
                ssn[t] = pn_q[t-2];
            end
        end
        e_vld[0] = 1'b0; e_stuck[0] = 1'b0; e_err[0] = 1'b0; e_spd[0] = '0;
        for (int t = 0; t < n - 1; t++) begin
            if (r_q[t]) begin
                sv = '0; err = 1'b0; run = 0; last_edge = -1; stuck_at = -1; anchor = t + 1;
                e_vld[t+1] = 1'b0; e_stuck[t+1] = 1'b0; e_err[t+1] = 1'b0; e_spd[t+1] = '0;
                continue;
            end
            v    = 1'b0;
            rise = ss[t] && (t == 0 || !ss[t-1]);
            if (rise) begin
                if (stuck_at < 0 && last_edge >= 0 && t - last_edge == PERIOD) begin
                    h = 0;
                    for (int i = last_edge; i < t; i++) h += int'(ss[i]);
                    if (h > PERIOD - 1) h = PERIOD - 1;
                    sv = 11'(h - 'h400);
                    v  = 1'b1;
                end
                last_edge = t;
                stuck_at  = -1;
            end else if (stuck_at < 0) begin
                ref_t = (last_edge >= 0) ? last_edge : anchor;
                if (t - ref_t == TMO - 1) stuck_at = t + 1;
            end else if ((t - stuck_at) % PERIOD == PERIOD - 1) begin
                sv = ss[t] ? 11'h3FF : 11'h400;
                v  = 1'b1;
            end
            if (v) exp_q.push_back(sv);
            run = (ss[t] == ssn[t]) ? run + 1 : 0;
            if (run > MAXEQ) err = 1'b1;
            e_vld[t+1]   = v;
            e_spd[t+1]   = sv;
            e_stuck[t+1] = (stuck_at >= 0);
            e_err[t+1]   = err;
        end
    endfunction

    initial begin
        logic [10:0] e;
        n_chk     = 0;
        n_err     = 0;
        cyc       = 0;
        rst       = 1'b1;
        pwm_sig   = 1'b0;
        pwm_sig_n = 1'b1;

        put(1'b0, 1'b1, 1'b1, 4);
        put(1'b0, 1'b1, 1'b0, 30 + $urandom_range(0, 40));
        repeat (4) pwm(1024, PERIOD, 0, 0);
        pwm(2047, PERIOD, 0, 0);
        pwm(1, PERIOD, 0, 0);
        repeat (4) pwm($urandom_range(1, PERIOD - 1), PERIOD, 0, 0);
        pwm(1000, 2000, 0, 0);
        pwm(1024, PERIOD, 0, 0);
        pwm($urandom_range(1, PERIOD - 1), PERIOD, 0, 0);
        pwm(700, PERIOD + $urandom_range(1, 60), 0, 0);
        pwm(1024, PERIOD, 300, 2);
        pwm(1024, PERIOD, 0, 0);
        put(1'b1, 1'b0, 1'b0, 5000);
        repeat (3) pwm(1024, PERIOD, 0, 0);
        pwm(1024, PERIOD, 500, 3);
        pwm(1024, PERIOD, 0, 0);
        pwm(1024, 1000, 0, 0);
        put(1'b0, 1'b1, 1'b1, 2);
        put(1'b0, 1'b1, 1'b0, PERIOD - 1002);
        repeat (3) pwm($urandom_range(1, PERIOD - 1), PERIOD, 0, 0);
        put(1'b0, 1'b1, 1'b0, 4500);
        repeat (2) pwm(1024, PERIOD, 0, 0);
        put(1'b0, 1'b1, 1'b0, 20);

        build_model();

        for (int k = 0; k < p_q.size(); k++) begin
            @(posedge clk);
            #1;
            pwm_sig   = p_q[k];
            pwm_sig_n = pn_q[k];
            rst       = r_q[k];
            @(negedge clk);
            cyc = k;
            check("vld", 32'(vld), 32'(e_vld[k]));
            check("spd", 32'(spd), 32'(e_spd[k]));
            check("stuck", 32'(stuck), 32'(e_stuck[k]));
            check("comp_err", 32'(comp_err), 32'(e_err[k]));
            if (vld === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_spd", 32'(spd), 32'(e));
                end else begin
                    check("sb_unexpected_vld", 32'd1, 32'd0);
                end
            end
        end
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
